// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite slave owning NUM_REGS control registers, exported flat on regs_o; B one edge after AW+W both held, R one edge after AR.
// One outstanding write and one outstanding read; AW/W stall while B waits on B_READY, AR stalls while R waits on R_READY.
module axi4lite_reg_slave #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS       = 8
) (
  input  logic                               A_CLK,
  input  logic                               A_RST,
  input  logic                               AW_VALID,
  output logic                               AW_READY,
  input  logic [AXI_ADDR_WIDTH-1:0]          AW_ADDR,
  input  logic                               W_VALID,
  output logic                               W_READY,
  input  logic [AXI_DATA_WIDTH-1:0]          W_DATA,
  output logic                               B_VALID,
  input  logic                               B_READY,
  output logic [1:0]                         B_RESP,
  input  logic                               AR_VALID,
  output logic                               AR_READY,
  input  logic [AXI_ADDR_WIDTH-1:0]          AR_ADDR,
  output logic                               R_VALID,
  input  logic                               R_READY,
  output logic [AXI_DATA_WIDTH-1:0]          R_DATA,
  output logic [1:0]                         R_RESP,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] regs_o
);

  localparam int OFS  = $clog2(AXI_DATA_WIDTH / 8);
  localparam int IDXW = $clog2(NUM_REGS);
  localparam int TOP  = IDXW + OFS;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WR_COLLECT, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic                      live;
  logic                      aw_held, w_held;
  logic [IDXW-1:0]           aw_idx_q;
  logic                      aw_ok_q;
  logic [AXI_DATA_WIDTH-1:0] w_data_q;
  logic [AXI_DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                      do_write;
  logic                      aw_hs, w_hs, ar_hs;

  logic [IDXW-1:0] aw_idx, ar_idx;
  logic            aw_ok, ar_ok;
  logic            unused_addr_bits;

  // Byte-offset bits are dropped so unaligned addresses hit the containing word.
  assign aw_idx = AW_ADDR[TOP-1:OFS];
  assign ar_idx = AR_ADDR[TOP-1:OFS];
  assign aw_ok  = (AW_ADDR[AXI_ADDR_WIDTH-1:TOP] == '0);
  assign ar_ok  = (AR_ADDR[AXI_ADDR_WIDTH-1:TOP] == '0);
  assign unused_addr_bits = &{1'b0, AW_ADDR[OFS-1:0], AR_ADDR[OFS-1:0]};

  assign aw_hs = AW_VALID & AW_READY;
  assign w_hs  = W_VALID & W_READY;
  assign ar_hs = AR_VALID & AR_READY;

  // Keeps all readies low while reset is held and for the release cycle.
  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) live <= 1'b0;
    else       live <= 1'b1;
  end

  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) begin
      wr_state <= WR_COLLECT;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_COLLECT: if (aw_held && w_held) wr_next = WR_RESP;
      WR_RESP:    if (B_READY)           wr_next = WR_COLLECT;
      default:                           wr_next = WR_COLLECT;
    endcase
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_hs)   rd_next = RD_DATA;
      RD_DATA: if (R_READY) rd_next = RD_IDLE;
      default:              rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    AW_READY = live & ~aw_held & (wr_state == WR_COLLECT);
    W_READY  = live & ~w_held & (wr_state == WR_COLLECT);
    B_VALID  = (wr_state == WR_RESP);
    do_write = (wr_state == WR_COLLECT) & aw_held & w_held;
    AR_READY = live & (rd_state == RD_IDLE);
    R_VALID  = (rd_state == RD_DATA);
  end

  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      aw_ok_q  <= 1'b0;
      w_data_q <= '0;
      B_RESP   <= RESP_OKAY;
      R_DATA   <= '0;
      R_RESP   <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        aw_idx_q <= aw_idx;
        aw_ok_q  <= aw_ok;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= W_DATA;
      end
      if (do_write) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        B_RESP  <= aw_ok_q ? RESP_OKAY : RESP_SLVERR;
        if (aw_ok_q) regs_q[aw_idx_q] <= w_data_q;
      end
      // Reads sample the bank before any write landing on the same edge.
      if (ar_hs) begin
        R_DATA <= ar_ok ? regs_q[ar_idx] : '0;
        R_RESP <= ar_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_o[g*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Directed bench for axi4lite_reg_slave with a cycle-level register-bank model checked every falling edge.
module tb_axi4lite_reg_slave;

  logic         A_CLK, A_RST;
  logic         AW_VALID, AW_READY;
  logic [31:0]  AW_ADDR;
  logic         W_VALID, W_READY;
  logic [31:0]  W_DATA;
  logic         B_VALID, B_READY;
  logic [1:0]   B_RESP;
  logic         AR_VALID, AR_READY;
  logic [31:0]  AR_ADDR;
  logic         R_VALID, R_READY;
  logic [31:0]  R_DATA;
  logic [1:0]   R_RESP;
  logic [255:0] regs_o;

  int tests = 0;
  int fails = 0;
  int b_count = 0;

  axi4lite_reg_slave #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .NUM_REGS(8)) dut (
    .A_CLK(A_CLK), .A_RST(A_RST),
    .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR),
    .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP),
    .regs_o(regs_o)
  );

  initial A_CLK = 1'b0;
  always #5 A_CLK = ~A_CLK;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model of the slave: register bank, captured AW/W, outstanding B and R.
  logic [31:0] m_regs [8];
  logic        m_live, m_have_aw, m_have_w, m_b_out, m_r_out;
  logic [31:0] m_aw_addr, m_w_data, m_r_data;
  logic [1:0]  m_b_resp, m_r_resp;

  function automatic logic in_range(input logic [31:0] a);
    return (a >> 5) == 0;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) & 32'd7);
  endfunction

  always @(negedge A_CLK) begin
    logic [255:0] exp_flat;
    logic e_awr, e_wr, e_arr;
    for (int i = 0; i < 8; i++) exp_flat[i*32 +: 32] = m_regs[i];
    if (A_RST) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
      m_live = 0; m_have_aw = 0; m_have_w = 0; m_b_out = 0; m_r_out = 0;
      check("rst_aw_ready", AW_READY, 0);
      check("rst_ar_ready", AR_READY, 0);
      check("rst_b_valid", B_VALID, 0);
      check("rst_r_valid", R_VALID, 0);
      check("rst_b_resp", B_RESP, 0);
      check("rst_r_data", R_DATA, 0);
      check("rst_r_resp", R_RESP, 0);
      check("rst_regs", regs_o, 256'h0);
    end else begin
      e_awr = m_live & !m_have_aw & !m_b_out;
      e_wr  = m_live & !m_have_w & !m_b_out;
      e_arr = m_live & !m_r_out;
      check("m_aw_ready", AW_READY, e_awr);
      check("m_w_ready", W_READY, e_wr);
      check("m_ar_ready", AR_READY, e_arr);
      check("m_b_valid", B_VALID, m_b_out);
      check("m_r_valid", R_VALID, m_r_out);
      check("m_regs", regs_o, exp_flat);
      if (m_b_out) check("m_b_resp", B_RESP, m_b_resp);
      if (m_r_out) begin
        check("m_r_data", R_DATA, m_r_data);
        check("m_r_resp", R_RESP, m_r_resp);
      end
      if (B_VALID && B_READY) b_count++;
      // Advance the model to the state after the coming rising edge.
      if (m_r_out && R_READY) m_r_out = 0;
      if (AR_VALID && e_arr) begin
        m_r_out  = 1;
        m_r_data = in_range(AR_ADDR) ? m_regs[idx_of(AR_ADDR)] : 32'h0;
        m_r_resp = in_range(AR_ADDR) ? 2'b00 : 2'b10;
      end
      if (m_b_out && B_READY) m_b_out = 0;
      if (m_have_aw && m_have_w) begin
        if (in_range(m_aw_addr)) m_regs[idx_of(m_aw_addr)] = m_w_data;
        m_b_resp  = in_range(m_aw_addr) ? 2'b00 : 2'b10;
        m_b_out   = 1;
        m_have_aw = 0;
        m_have_w  = 0;
      end else begin
        if (AW_VALID && e_awr) begin m_have_aw = 1; m_aw_addr = AW_ADDR; end
        if (W_VALID && e_wr)   begin m_have_w = 1;  m_w_data = W_DATA;   end
      end
      m_live = 1;
    end
  end

  // Drivers: entered #1 after a rising edge, return #1 after the handshake edge.
  task automatic send_aw(input logic [31:0] addr);
    int n;
    n = 0;
    AW_ADDR = addr; AW_VALID = 1;
    @(negedge A_CLK);
    while (!AW_READY && n < 50) begin @(negedge A_CLK); n++; end
    if (n >= 50) check("aw_timeout", 0, 1);
    @(posedge A_CLK); #1;
    AW_VALID = 0;
  endtask

  task automatic send_w(input logic [31:0] data);
    int n;
    n = 0;
    W_DATA = data; W_VALID = 1;
    @(negedge A_CLK);
    while (!W_READY && n < 50) begin @(negedge A_CLK); n++; end
    if (n >= 50) check("w_timeout", 0, 1);
    @(posedge A_CLK); #1;
    W_VALID = 0;
  endtask

  task automatic send_ar(input logic [31:0] addr);
    int n;
    n = 0;
    AR_ADDR = addr; AR_VALID = 1;
    @(negedge A_CLK);
    while (!AR_READY && n < 50) begin @(negedge A_CLK); n++; end
    if (n >= 50) check("ar_timeout", 0, 1);
    @(posedge A_CLK); #1;
    AR_VALID = 0;
  endtask

  task automatic write_both(input logic [31:0] addr, input logic [31:0] data);
    fork
      send_aw(addr);
      send_w(data);
    join
  endtask

  // Returns on a falling edge where B_VALID is high.
  task automatic wait_b();
    int n;
    n = 0;
    @(negedge A_CLK);
    while (!B_VALID && n < 20) begin @(negedge A_CLK); n++; end
    if (n >= 20) check("b_timeout", 0, 1);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge A_CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b0;
    A_RST = 1; AW_VALID = 0; AW_ADDR = 0; W_VALID = 0; W_DATA = 0;
    B_READY = 1; AR_VALID = 0; AR_ADDR = 0; R_READY = 1;
    repeat (3) @(posedge A_CLK);
    @(negedge A_CLK);
    check("reset_ar_ready", AR_READY, 0);
    check("reset_regs", regs_o, 256'h0);
    step(1);
    A_RST = 0;
    step(2);
    @(negedge A_CLK);
    check("post_reset_ar_ready", AR_READY, 1);
    check("post_reset_aw_ready", AW_READY, 1);
    step(1);

    // Same-cycle AW and W: B one edge after the handshake edge.
    write_both(32'h04, 32'hDEADBEEF);
    @(negedge A_CLK);
    check("t1_b_not_yet", B_VALID, 0);
    @(negedge A_CLK);
    check("t1_b_valid", B_VALID, 1);
    check("t1_b_resp", B_RESP, 2'b00);
    check("t1_reg1", regs_o[63:32], 32'hDEADBEEF);
    step(2);

    // W three cycles ahead of AW.
    b0 = b_count;
    send_w(32'h12345678);
    for (int i = 0; i < 3; i++) begin
      @(negedge A_CLK);
      check("t2_w_ready_low", W_READY, 0);
      step(1);
    end
    send_aw(32'h08);
    step(5);
    check("t2_one_b", b_count - b0, 1);
    check("t2_reg2", regs_o[95:64], 32'h12345678);

    // Unaligned address lands on word 0.
    write_both(32'h03, 32'hCAFEF00D);
    step(4);
    check("unaligned_reg0", regs_o[31:0], 32'hCAFEF00D);

    // Out of range write and read.
    write_both(32'h40, 32'hFFFFFFFF);
    wait_b();
    check("t3_b_resp", B_RESP, 2'b10);
    step(2);
    check("t3_regs", regs_o, {160'h0, 32'h12345678, 32'hDEADBEEF, 32'hCAFEF00D});
    send_ar(32'h40);
    @(negedge A_CLK);
    check("t3_r_valid", R_VALID, 1);
    check("t3_r_data", R_DATA, 32'h0);
    check("t3_r_resp", R_RESP, 2'b10);
    step(2);

    // B backpressure.
    B_READY = 0;
    write_both(32'h10, 32'h0BADF00D);
    wait_b();
    for (int i = 0; i < 5; i++) begin
      check("t4_b_valid", B_VALID, 1);
      check("t4_b_resp", B_RESP, 2'b00);
      check("t4_aw_ready", AW_READY, 0);
      check("t4_w_ready", W_READY, 0);
      step(1);
      @(negedge A_CLK);
    end
    step(1);
    B_READY = 1;
    step(2);

    // R backpressure.
    R_READY = 0;
    send_ar(32'h10);
    @(negedge A_CLK);
    for (int i = 0; i < 5; i++) begin
      check("t4_r_valid", R_VALID, 1);
      check("t4_r_data", R_DATA, 32'h0BADF00D);
      check("t4_ar_ready", AR_READY, 0);
      step(1);
      @(negedge A_CLK);
    end
    step(1);
    R_READY = 1;
    step(2);

    // Read handshake on the same edge as the write to reg3.
    write_both(32'h0C, 32'hA5A5A5A5);
    send_ar(32'h0C);
    @(negedge A_CLK);
    check("t5_r_valid", R_VALID, 1);
    check("t5_pre_write", R_DATA, 32'h0);
    check("t5_reg3", regs_o[127:96], 32'hA5A5A5A5);
    step(3);
    send_ar(32'h0C);
    @(negedge A_CLK);
    check("t5_post_write", R_DATA, 32'hA5A5A5A5);
    step(2);

    // Reset with B and R both pending.
    B_READY = 0;
    R_READY = 0;
    write_both(32'h14, 32'h55AA55AA);
    send_ar(32'h04);
    @(negedge A_CLK);
    check("t6_b_pending", B_VALID, 1);
    check("t6_r_pending", R_VALID, 1);
    check("t6_r_data", R_DATA, 32'hDEADBEEF);
    step(1);
    #2;
    A_RST = 1;
    #1;
    check("t6_b_valid", B_VALID, 0);
    check("t6_r_valid", R_VALID, 0);
    check("t6_r_data_zero", R_DATA, 0);
    check("t6_b_resp", B_RESP, 0);
    check("t6_aw_ready", AW_READY, 0);
    check("t6_ar_ready", AR_READY, 0);
    check("t6_regs", regs_o, 256'h0);
    step(2);
    A_RST = 0;
    B_READY = 1;
    R_READY = 1;
    step(2);
    @(negedge A_CLK);
    check("t6_ar_ready_after", AR_READY, 1);
    check("t6_aw_ready_after", AW_READY, 1);
    check("t6_w_ready_after", W_READY, 1);
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
